// File: rtl/skin_bbox.sv
// skin_bbox: per-frame bounding box of skin pixels from the skindet mask.
// Tracks min/max X/Y of pixels with iY >= SKIN_THR while a frame is active,
// publishes the box one cycle after frame end, and re-times the RGB stream.
// Optional feature macro: SKIN_BBOX_OVERLAY_EN draws the published box border
// in green over the following frame's RGB stream.
module skin_bbox #(
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned SKIN_THR   = 128,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [7:0]         iY,
  input  logic [7:0]         iR,
  input  logic [7:0]         iG,
  input  logic [7:0]         iB,
  input  logic               iLineValid,
  input  logic               iFrameValid,
  output logic [7:0]         oR,
  output logic [7:0]         oG,
  output logic [7:0]         oB,
  output logic               oLineValid,
  output logic               oFrameValid,
  output logic [COORD_W-1:0] oXMin,
  output logic [COORD_W-1:0] oXMax,
  output logic [COORD_W-1:0] oYMin,
  output logic [COORD_W-1:0] oYMax,
  output logic               oBoxValid,
  output logic               oFrameDone
);

  localparam int unsigned CNT_W = 2 * COORD_W;
  localparam logic [7:0]       THR  = 8'(SKIN_THR);
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, ACTIVE, LATCH} state_e;

  state_e             state_q, state_d;
  logic               fv_q, lv_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] wxmin_q, wxmin_d, wxmax_q, wxmax_d;
  logic [COORD_W-1:0] wymin_q, wymin_d, wymax_q, wymax_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               publish;
  logic               fv_rise, fv_fall, lv_fall, pix, skin;
  logic [7:0]         r_d, g_d, b_d;

  assign fv_rise = iFrameValid & ~fv_q;
  assign fv_fall = ~iFrameValid & fv_q;
  assign lv_fall = ~iLineValid & lv_q;
  assign pix     = iLineValid & iFrameValid;
  assign skin    = pix && (iY >= THR);

  // Pixel coordinate counters; clears take priority over increments, both saturate.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (lv_fall)
      x_d = '0;
    else if (pix && (x_q != '1))
      x_d = x_q + 1'b1;
    if (fv_rise)
      y_d = '0;
    else if (lv_fall && iFrameValid && (y_q != '1))
      y_d = y_q + 1'b1;
  end

  // Frame FSM next state plus work-box tracking.
  always_comb begin
    state_d = state_q;
    wxmin_d = wxmin_q;
    wxmax_d = wxmax_q;
    wymin_d = wymin_q;
    wymax_d = wymax_q;
    cnt_d   = cnt_q;
    publish = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fv_rise) begin
          state_d = ACTIVE;
          wxmin_d = '1;
          wxmax_d = '0;
          wymin_d = '1;
          wymax_d = '0;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (fv_fall) begin
          state_d = LATCH;
        end else if (skin) begin
          if (x_q < wxmin_q) wxmin_d = x_q;
          if (x_q > wxmax_q) wxmax_d = x_q;
          if (y_q < wymin_q) wymin_d = y_q;
          if (y_q > wymax_q) wymax_d = y_q;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        publish = 1'b1;
        if (iFrameValid) begin
          state_d = ACTIVE;
          wxmin_d = '1;
          wxmax_d = '0;
          wymin_d = '1;
          wymax_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SKIN_BBOX_OVERLAY_EN
  logic in_x, in_y, border;

  // Border test against the published (previous frame's) box.
  always_comb begin
    in_x   = (x_q >= oXMin) && (x_q <= oXMax);
    in_y   = (y_q >= oYMin) && (y_q <= oYMax);
    border = oBoxValid && pix &&
             ((((x_q == oXMin) || (x_q == oXMax)) && in_y) ||
              (((y_q == oYMin) || (y_q == oYMax)) && in_x));
    r_d = iR;
    g_d = iG;
    b_d = iB;
    if (border) begin
      r_d = 8'h00;
      g_d = 8'hFF;
      b_d = 8'h00;
    end
  end
`else
  // RGB passes straight through to the output register.
  always_comb begin
    r_d = iR;
    g_d = iG;
    b_d = iB;
  end
`endif

  // State, counters, published box and video re-timing registers.
  // Edge regs preset to 1 so a frame already running at reset release is skipped.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= IDLE;
      fv_q        <= 1'b1;
      lv_q        <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      wxmin_q     <= '0;
      wxmax_q     <= '0;
      wymin_q     <= '0;
      wymax_q     <= '0;
      cnt_q       <= '0;
      oXMin       <= '0;
      oXMax       <= '0;
      oYMin       <= '0;
      oYMax       <= '0;
      oBoxValid   <= 1'b0;
      oFrameDone  <= 1'b0;
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
      oLineValid  <= 1'b0;
      oFrameValid <= 1'b0;
    end else begin
      state_q     <= state_d;
      fv_q        <= iFrameValid;
      lv_q        <= iLineValid;
      x_q         <= x_d;
      y_q         <= y_d;
      wxmin_q     <= wxmin_d;
      wxmax_q     <= wxmax_d;
      wymin_q     <= wymin_d;
      wymax_q     <= wymax_d;
      cnt_q       <= cnt_d;
      oFrameDone  <= publish;
      if (publish) begin
        oXMin     <= wxmin_q;
        oXMax     <= wxmax_q;
        oYMin     <= wymin_q;
        oYMax     <= wymax_q;
        oBoxValid <= (cnt_q >= MINP);
      end
      oR          <= r_d;
      oG          <= g_d;
      oB          <= b_d;
      oLineValid  <= iLineValid;
      oFrameValid <= iFrameValid;
    end
  end

endmodule
